// File: rtl/ieee754_pkg.sv
// Definitions shared by the single-precision arithmetic units:
// format constants, divider FSM states, operand classes and exception flags.
package ieee754_pkg;

    localparam int unsigned EXP_BIAS = 127;
    localparam int unsigned EXP_MAX  = 255;
    localparam int unsigned FRAC_W   = 23;
    localparam int unsigned MANT_W   = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_NORM
    } state_e;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_INF,
        CLS_NORMAL
    } cls_e;

    typedef struct packed {
        logic div_by_zero;
        logic invalid;
        logic overflow;
        logic underflow;
    } flags_t;

endpackage

// File: rtl/ieee754_classify.sv
// Splits a binary32 operand into sign, exponent and mantissa (hidden bit set).
// Denormals classify as zero and every exp=255 encoding classifies as infinity.
module ieee754_classify
    import ieee754_pkg::*;
(
    input  logic [31:0]       op_i,
    output logic              sign_o,
    output logic [7:0]        exp_o,
    output logic [MANT_W-1:0] mant_o,
    output cls_e              cls_o
);

    always_comb begin
        sign_o = op_i[31];
        exp_o  = op_i[30:23];
        mant_o = {1'b1, op_i[FRAC_W-1:0]};
        if (exp_o == '0) begin
            cls_o = CLS_ZERO;
        end else if (exp_o == '1) begin
            cls_o = CLS_INF;
        end else begin
            cls_o = CLS_NORMAL;
        end
    end

endmodule

// File: rtl/ieee754_div.sv
// Sequential binary32 divider: restoring shift-subtract, one quotient bit per
// clock, fixed 26-clock latency from accept to done, truncating result.
module ieee754_div
    import ieee754_pkg::*;
#(
    parameter logic [31:0] NAN_VALUE = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        div_by_zero,
    output logic        invalid,
    output logic        overflow,
    output logic        underflow
);

    localparam int unsigned DIV_ITERS = 25;

    state_e              state_q, state_d;
    logic [31:0]         a_q, a_d, b_q, b_d;
    logic [25:0]         r_q, r_d;
    logic [24:0]         q_q, q_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [31:0]         result_q, result_d;
    flags_t              flags_q, flags_d;

    logic                sign_a, sign_b;
    logic [7:0]          exp_a, exp_b;
    logic [MANT_W-1:0]   mant_a, mant_b;
    cls_e                cls_a, cls_b;

    ieee754_classify u_cls_a (
        .op_i   (a_q),
        .sign_o (sign_a),
        .exp_o  (exp_a),
        .mant_o (mant_a),
        .cls_o  (cls_a)
    );

    ieee754_classify u_cls_b (
        .op_i   (b_q),
        .sign_o (sign_b),
        .exp_o  (exp_b),
        .mant_o (mant_b),
        .cls_o  (cls_b)
    );

    // Normaliser and special-case resolution, consumed on the NORM edge.
    logic               res_sign;
    logic signed [9:0]  e_raw, e_fin;
    logic [FRAC_W-1:0]  frac;
    logic [31:0]        norm_result;
    flags_t             norm_flags;

    always_comb begin
        res_sign    = sign_a ^ sign_b;
        e_raw       = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b})
                      + $signed(10'(EXP_BIAS));
        e_fin       = q_q[24] ? e_raw : e_raw - 10'sd1;
        frac        = q_q[24] ? q_q[23:1] : q_q[22:0];
        norm_result = {res_sign, e_fin[7:0], frac};
        norm_flags  = '0;
        if ((cls_a == CLS_ZERO && cls_b == CLS_ZERO) ||
            (cls_a == CLS_INF  && cls_b == CLS_INF)) begin
            norm_result        = NAN_VALUE;
            norm_flags.invalid = 1'b1;
        end else if (cls_a == CLS_INF) begin
            norm_result = {res_sign, 8'hFF, 23'd0};
        end else if (cls_a == CLS_ZERO) begin
            norm_result = {res_sign, 31'd0};
        end else if (cls_b == CLS_ZERO) begin
            norm_result            = {res_sign, 8'hFF, 23'd0};
            norm_flags.div_by_zero = 1'b1;
        end else if (cls_b == CLS_INF) begin
            norm_result = {res_sign, 31'd0};
        end else if (e_fin >= $signed(10'(EXP_MAX))) begin
            norm_result         = {res_sign, 8'hFF, 23'd0};
            norm_flags.overflow = 1'b1;
        end else if (e_fin <= 10'sd0) begin
            norm_result          = {res_sign, 31'd0};
            norm_flags.underflow = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            q_q      <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_DIV;
            ST_DIV:  if (cnt_q == 5'(DIV_ITERS - 1)) state_d = ST_NORM;
            ST_NORM: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    logic        q_bit;
    logic [25:0] rem;

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        q_d      = q_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        flags_d  = flags_q;
        q_bit    = (r_q >= {2'b00, mant_b});
        rem      = q_bit ? r_q - {2'b00, mant_b} : r_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    // Remainder seeds from the live input since a_q is not yet loaded.
                    r_d     = {3'b001, a[FRAC_W-1:0]};
                    q_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    flags_d = '0;
                end
            end
            ST_DIV: begin
                r_d   = {rem[24:0], 1'b0};
                q_d   = {q_q[23:0], q_bit};
                cnt_d = cnt_q + 5'd1;
            end
            ST_NORM: begin
                result_d = norm_result;
                flags_d  = norm_flags;
                done_d   = 1'b1;
                busy_d   = 1'b0;
            end
            default: ;
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign div_by_zero = flags_q.div_by_zero;
    assign invalid     = flags_q.invalid;
    assign overflow    = flags_q.overflow;
    assign underflow   = flags_q.underflow;

endmodule

// File: tb/tb_ieee754_div.sv
// Directed scoreboard bench for ieee754_div: fixed latency, handshake,
// special operands, range limits and asynchronous reset abort.
module tb_ieee754_div;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div_by_zero, invalid, overflow, underflow;
    logic [31:0] result;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail = 0;

    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_DBZ  = 4'b1000;
    localparam logic [3:0] F_INV  = 4'b0100;
    localparam logic [3:0] F_OVF  = 4'b0010;
    localparam logic [3:0] F_UNF  = 4'b0001;

    ieee754_div #(.NAN_VALUE(32'h7FC0_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero),
        .invalid     (invalid),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] flags_now();
        return {div_by_zero, invalid, overflow, underflow};
    endfunction

    // Drive one accepted start; the accept edge is the next rising edge.
    task automatic do_accept(input logic [31:0] av, input logic [31:0] bv,
                             input logic [31:0] res, input logic [3:0] flg);
        exp_t e;
        e.a = av; e.b = bv; e.res = res; e.flg = flg;
        sb.push_back(e);
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done (bounded), optionally presenting a start at edge inject_at.
    task automatic wait_result(input string tag, input int inject_at,
                               input logic [31:0] ia, input logic [31:0] ib);
        int   lat;
        exp_t e;
        lat = 41;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) check({tag, "_busy_early"}, 32'(busy), 32'd1);
            if (n == inject_at) begin
                a = ia;
                b = ib;
                start = 1'b1;
            end
            if (done) begin
                lat = n;
                break;
            end
        end
        check({tag, "_latency"}, 32'(lat), 32'd26);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_result"}, result, e.res);
            check({tag, "_flags"}, 32'(flags_now()), 32'(e.flg));
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] res, input logic [3:0] flg);
        do_accept(av, bv, res, flg);
        wait_result(tag, 0, '0, '0);
    endtask

    initial begin
        int seen_done;

        #3;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", 32'(flags_now()), 32'd0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("div6_2",     32'h40C00000, 32'h40000000, 32'h40400000, F_NONE);
        run_op("div1_3",     32'h3F800000, 32'h40400000, 32'h3EAAAAAA, F_NONE);
        run_op("divm75_25",  32'hC0F00000, 32'h40200000, 32'hC0400000, F_NONE);
        run_op("divm1_0",    32'hBF800000, 32'h00000000, 32'hFF800000, F_DBZ);
        run_op("div0_0",     32'h00000000, 32'h00000000, 32'h7FC00000, F_INV);
        run_op("divinf_inf", 32'h7F800000, 32'h7F800000, 32'h7FC00000, F_INV);
        run_op("ovf",        32'h7F000000, 32'h3E800000, 32'h7F800000, F_OVF);
        run_op("unf",        32'h00800000, 32'h40000000, 32'h00000000, F_UNF);
        run_op("div0_5",     32'h00000000, 32'h40A00000, 32'h00000000, F_NONE);
        run_op("divinf_2",   32'hFF800000, 32'h40000000, 32'hFF800000, F_NONE);
        run_op("div2_inf",   32'h40000000, 32'hFF800000, 32'h80000000, F_NONE);

        // Busy start is ignored; start held into the done cycle is accepted.
        do_accept(32'h40C00000, 32'h40000000, 32'h40400000, F_NONE);
        wait_result("hs_ignore", 5, 32'h3F800000, 32'h40400000);
        begin
            exp_t e;
            e.a = 32'h3F800000; e.b = 32'h40400000; e.res = 32'h3EAAAAAA; e.flg = F_NONE;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        check("hs_accept_busy", 32'(busy), 32'd1);
        wait_result("hs_done_cycle", 0, '0, '0);

        // Asynchronous reset mid-division.
        do_accept(32'h40C00000, 32'h40000000, 32'h40400000, F_NONE);
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_flags", 32'(flags_now()), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        seen_done = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);
        run_op("post_rst", 32'h40C00000, 32'h40000000, 32'h40400000, F_NONE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
